// File: rtl/mult4_dot_accum_pkg.sv
// Shared types and default widths for the dot-product accumulator stage.
package mult4_dot_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int ACC_W_DEF = 12;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mult4_dot_accum_main.sv
// Combinational 4x4 unsigned multiplier core.
module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);

  assign o = {4'b0000, x} * {4'b0000, y};

endmodule

// File: rtl/mult4_dot_accum.sv
// Streaming dot-product stage: registers operand pairs into the 4x4 core,
// accumulates the products per packet and holds the packet result on a valid/ready port.
module mult4_dot_accum
  import mult4_dot_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  logic [3:0]       x_p1, y_p1;
  logic             last_p1, vld_p1;
  logic [7:0]       prod_c;
  logic [7:0]       prod_p2;
  logic             last_p2, vld_p2;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  state_t           state, state_nxt;

  logic             blk, s1_adv, s2_adv, acc_fire, last_fire, consume;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_sat;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_nxt;

  function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W:0] w);
    return w[ACC_W] ? {ACC_W{1'b1}} : w[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Only a last product waiting on an unconsumed result stalls the pipe.
  assign out_valid = (state == HOLD);
  assign consume   = out_valid && out_ready;
  assign blk       = vld_p2 && last_p2 && out_valid && !out_ready;
  assign s2_adv    = !blk;
  assign s1_adv    = !vld_p1 || s2_adv;
  assign in_ready  = s1_adv;
  assign acc_fire  = s2_adv && vld_p2;
  assign last_fire = acc_fire && last_p2;

  assign sum_wide = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod_p2};
  assign sum_sat  = sat_sum(sum_wide);
  assign cnt_inc  = sat_inc(cnt);
  assign ovf_nxt  = ovf | sum_wide[ACC_W];

  // S1: operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p1    <= '0;
      y_p1    <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (s1_adv) begin
      x_p1    <= in_x;
      y_p1    <= in_y;
      last_p1 <= in_last;
      vld_p1  <= in_valid;
    end
  end

  main u_core (
    .x (x_p1),
    .y (y_p1),
    .o (prod_c)
  );

  // S2: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p2 <= '0;
      last_p2 <= 1'b0;
      vld_p2  <= 1'b0;
    end else if (s2_adv) begin
      prod_p2 <= prod_c;
      last_p2 <= last_p1;
      vld_p2  <= vld_p1;
    end
  end

  // Accumulator and result registers; a last product empties the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (acc_fire) begin
      if (last_p2) begin
        out_sum <= sum_sat;
        out_cnt <= cnt_inc;
        out_ovf <= ovf_nxt;
        acc     <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
      end else begin
        acc     <= sum_sat;
        cnt     <= cnt_inc;
        ovf     <= ovf_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (last_fire)     state_nxt = HOLD;
        else if (acc_fire) state_nxt = ACC;
      end
      ACC: begin
        if (last_fire) state_nxt = HOLD;
      end
      HOLD: begin
        // A last product only fires here when the held result is consumed.
        if (!last_fire && consume) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult4_dot_accum.sv
// Scoreboard bench for mult4_dot_accum: two widths driven by one stream, checked against packet sums.
module tb_mult4_dot_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [3:0] in_x = '0, in_y = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [11:0] a_out_sum;
  logic [7:0]  a_out_cnt;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0]  b_out_sum;
  logic [7:0]  b_out_cnt;

  mult4_dot_accum #(.ACC_W(12), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
  );

  mult4_dot_accum #(.ACC_W(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
  );

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
  } res_t;

  res_t exp_a[$];
  res_t exp_b[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   msum = 0;
  int   mcnt = 0;

  function automatic res_t model(int s, int c, int w);
    res_t r;
    int   mx;
    mx    = (1 << w) - 1;
    r.sum = (s > mx) ? mx : s;
    r.ovf = (s > mx);
    r.cnt = (c > 255) ? 255 : c;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard whenever a result is consumed at the coming edge.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n && out_ready && a_out_valid) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result_a: got sum %0d expected none", a_out_sum);
        end else begin
          r = exp_a.pop_front();
          check("sum_a", a_out_sum, r.sum);
          check("cnt_a", a_out_cnt, r.cnt);
          check("ovf_a", a_out_ovf, r.ovf);
        end
        pop_cyc.push_back(cyc);
      end
      if (rst_n && out_ready && b_out_valid) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result_b: got sum %0d expected none", b_out_sum);
        end else begin
          r = exp_b.pop_front();
          check("sum_b", b_out_sum, r.sum);
          check("cnt_b", b_out_cnt, r.cnt);
          check("ovf_b", b_out_ovf, r.ovf);
        end
      end
    end
  end

  task automatic set_mode(input int m);
    rdy_mode = m;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic l, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      stalls++;
      if (stalls > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected 1", stalls);
        in_valid = 1'b0;
        return;
      end
    end
    msum += int'(x) * int'(y);
    mcnt++;
    if (l) begin
      exp_a.push_back(model(msum, mcnt, 12));
      exp_b.push_back(model(msum, mcnt, 8));
      msum = 0;
      mcnt = 0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    set_mode(0);
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", exp_a.size() + exp_b.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid_a"}, a_out_valid, 0);
    check({tag, "_sum_a"}, a_out_sum, 0);
    check({tag, "_cnt_a"}, a_out_cnt, 0);
    check({tag, "_ovf_a"}, a_out_ovf, 0);
    check({tag, "_valid_b"}, b_out_valid, 0);
    check({tag, "_sum_b"}, b_out_sum, 0);
  endtask

  initial begin
    int s, s1, s2;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", a_in_ready, 1);
    set_mode(0);

    // Basic packet and its latency
    send(4'd3, 4'd5, 1'b0, s);
    send(4'd15, 4'd15, 1'b0, s);
    send(4'd0, 4'd9, 1'b0, s);
    send(4'd2, 4'd7, 1'b1, s);
    check("lat_edge_k", a_out_valid, 0);
    idle(1);
    check("lat_edge_k1", a_out_valid, 0);
    idle(1);
    check("lat_edge_k2", a_out_valid, 1);
    drain();

    // Saturation on the narrow instance, then a clean packet
    send(4'd15, 4'd15, 1'b0, s);
    send(4'd15, 4'd15, 1'b1, s);
    send(4'd1, 4'd1, 1'b1, s);
    drain();

    // Back-to-back single-term packets
    pop_cyc.delete();
    send(4'd4, 4'd4, 1'b1, s1);
    send(4'd5, 4'd5, 1'b1, s2);
    check("b2b_stalls", s1 + s2, 0);
    drain();
    check("b2b_gap", (pop_cyc.size() >= 2) ? pop_cyc[1] - pop_cyc[0] : -1, 1);

    // Backpressure with a pending result
    set_mode(2);
    send(4'd9, 4'd1, 1'b1, s);
    idle(3);
    send(4'd1, 4'd2, 1'b0, s);
    send(4'd3, 4'd3, 1'b1, s);
    send(4'd2, 4'd2, 1'b0, s);
    check("blocked_ready", a_in_ready, 0);
    check("blocked_valid", a_out_valid, 1);
    idle(2);
    check("blocked_ready_hold", a_in_ready, 0);
    drain();
    send(4'd1, 4'd1, 1'b1, s);
    drain();

    // Reset mid-packet with a held result
    set_mode(2);
    send(4'd5, 4'd5, 1'b1, s);
    send(4'd7, 4'd7, 1'b0, s);
    send(4'd1, 4'd1, 1'b0, s);
    idle(3);
    rst_n = 1'b0;
    #2;
    check_zero("midreset");
    exp_a.delete();
    exp_b.delete();
    msum = 0;
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_mode(0);
    send(4'd2, 4'd3, 1'b1, s);
    drain();

    // Term counter saturation
    for (int i = 0; i < 299; i++) send(4'd15, 4'd15, 1'b0, s);
    send(4'd15, 4'd15, 1'b1, s);
    drain();

    // Random streams with random gaps and backpressure
    set_mode(1);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 4) == 0), s);
    end
    send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, s);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
